// File: rtl/load_store_unit_pkg.sv
// Shared load/store width codes, FSM state encoding and access-size helper
// for the load/store unit.
package load_store_unit_pkg;

    // funct3 width codes, kept identical to the core's shared definitions
    localparam logic [2:0] LOAD_B   = 3'b000;
    localparam logic [2:0] LOAD_H   = 3'b001;
    localparam logic [2:0] LOAD_W   = 3'b010;
    localparam logic [2:0] LOAD_BU  = 3'b100;
    localparam logic [2:0] LOAD_HU  = 3'b101;
    localparam logic [2:0] STORE_B  = 3'b000;
    localparam logic [2:0] STORE_H  = 3'b001;
    localparam logic [2:0] STORE_W  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    // Access size in bytes; reserved codes fall back to a full word.
    function automatic logic [2:0] access_size(input logic we, input logic [2:0] ctrl);
        logic [2:0] sz;
        sz = 3'd4;
        if (we) begin
            if (ctrl == STORE_B)      sz = 3'd1;
            else if (ctrl == STORE_H) sz = 3'd2;
        end else begin
            if (ctrl == LOAD_B || ctrl == LOAD_BU)      sz = 3'd1;
            else if (ctrl == LOAD_H || ctrl == LOAD_HU) sz = 3'd2;
        end
        return sz;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-bus interface between the load/store unit (master) and memory (slave).
// Handshake: a beat is offered while bus_req=1 and completes on the cycle
// bus_gnt=1; read data returns on a later cycle flagged by bus_rvalid=1.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane positioning for stores and shift/extend for loads,
// covering accesses that straddle a word boundary.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] beat0,
    input  logic [31:0] beat1,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] load_data
);
    logic [2:0]  size;
    logic [3:0]  mask;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [63:0] rd_wide;
    logic [31:0] rd_low;

    always_comb begin
        size = access_size(we, ctrl);
        mask = (size == 3'd1) ? 4'b0001 : ((size == 3'd2) ? 4'b0011 : 4'b1111);
        split = (({1'b0, offset}) + size) > 3'd4;

        // Upper halves of the widened shifts are exactly the beat1 lanes.
        be_wide = {4'b0000, mask} << offset;
        wd_wide = {32'h0, wdata} << {offset, 3'b000};
        rd_wide = {beat1, beat0} >> {offset, 3'b000};
        rd_low  = rd_wide[31:0];

        be0    = be_wide[3:0];
        be1    = be_wide[7:4];
        wdata0 = wd_wide[31:0];
        wdata1 = wd_wide[63:32];

        case (ctrl)
            LOAD_B:  load_data = {{24{rd_low[7]}}, rd_low[7:0]};
            LOAD_BU: load_data = {24'h0, rd_low[7:0]};
            LOAD_H:  load_data = {{16{rd_low[15]}}, rd_low[15:0]};
            LOAD_HU: load_data = {16'h0, rd_low[15:0]};
            default: load_data = rd_low;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word access into one or two aligned
// word-bus beats and returns an extended load result.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      mem_we,
    input  logic [2:0]                mem_ctrl,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [31:0]               wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rdata,
    load_store_unit_if.master         bus,
    output lsu_state_e                dbg_state
);
    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       beat0_q, beat0_d;
    logic [31:0]       beat1_q, beat1_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              split;
    logic [3:0]        be0, be1;
    logic [31:0]       wdata0, wdata1, load_data;
    logic [ADDR_W-1:0] word_addr;

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // Align sees next-cycle beat values so the result is ready on RESP entry.
    lsu_align u_align (
        .we        (we_q),
        .ctrl      (ctrl_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .beat0     (beat0_d),
        .beat1     (beat1_d),
        .split     (split),
        .be0       (be0),
        .be1       (be1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .load_data (load_data)
    );

    always_comb begin
        beat0_d = beat0_q;
        beat1_d = beat1_q;
        if (bus.bus_rvalid && state_q == ST_WAIT0) beat0_d = bus.bus_rdata;
        if (bus.bus_rvalid && state_q == ST_WAIT1) beat1_d = bus.bus_rdata;
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        ctrl_d        = ctrl_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_be    = 4'b0000;
        bus.bus_wdata = 32'h0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = mem_we;
                    ctrl_d  = mem_ctrl;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = ST_REQ0;
                end
            end
            ST_REQ0: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = we_q;
                bus.bus_addr  = word_addr;
                bus.bus_be    = be0;
                bus.bus_wdata = we_q ? wdata0 : 32'h0;
                if (bus.bus_gnt) begin
                    if (!we_q)     state_d = ST_WAIT0;
                    else if (split) state_d = ST_REQ1;
                    else           state_d = ST_RESP;
                end
            end
            ST_WAIT0: begin
                if (bus.bus_rvalid) state_d = split ? ST_REQ1 : ST_RESP;
            end
            ST_REQ1: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = we_q;
                bus.bus_addr  = word_addr + ADDR_W'(4);
                bus.bus_be    = be1;
                bus.bus_wdata = we_q ? wdata1 : 32'h0;
                if (bus.bus_gnt) state_d = we_q ? ST_RESP : ST_WAIT1;
            end
            ST_WAIT1: begin
                if (bus.bus_rvalid) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_RESP && state_q != ST_RESP) rdata_d = we_q ? 32'h0 : load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            ctrl_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            beat0_q <= 32'h0;
            beat1_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: the bench plays the word-bus memory and
// checks every beat, the response cycle and the returned data.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_we;
    logic [2:0]  mem_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    lsu_state_e  dbg_state;

    int checks;
    int failures;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_we    (mem_we),
        .mem_ctrl  (mem_ctrl),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; memory grants after 'stall' cycles on beat 0 and
    // returns read data the cycle after each grant.
    task automatic run_op(input string tag, input logic we, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] wd, input int stall,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] ea0, input logic [31:0] ea1,
                          input logic [3:0] eb0, input logic [3:0] eb1,
                          input logic [31:0] ewd0, input logic [31:0] ewd1,
                          input int nbeats, input logic [31:0] erd);
        logic [31:0] ea, ewd, w;
        logic [3:0]  eb;
        chk({tag, ":ready"}, req_ready, 1);
        req_valid = 1'b1;
        mem_we    = we;
        mem_ctrl  = ctrl;
        addr      = a;
        wdata     = wd;
        @(negedge clk);
        req_valid = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        for (int b = 0; b < nbeats; b++) begin
            ea  = (b == 0) ? ea0 : ea1;
            eb  = (b == 0) ? eb0 : eb1;
            ewd = (b == 0) ? ewd0 : ewd1;
            w   = (b == 0) ? w0 : w1;
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    chk($sformatf("%s:stall%0d_req", tag, s), bus.bus_req, 1);
                    chk($sformatf("%s:stall%0d_addr", tag, s), bus.bus_addr, ea);
                    bus.bus_gnt    = 1'b0;
                    bus.bus_rvalid = 1'b1;
                    bus.bus_rdata  = 32'hBAD0BAD0;
                    @(negedge clk);
                    bus.bus_rvalid = 1'b0;
                    bus.bus_rdata  = 32'h0;
                end
            end
            chk($sformatf("%s:b%0d_req", tag, b), bus.bus_req, 1);
            chk($sformatf("%s:b%0d_we", tag, b), bus.bus_we, we);
            chk($sformatf("%s:b%0d_addr", tag, b), bus.bus_addr, ea);
            chk($sformatf("%s:b%0d_be", tag, b), bus.bus_be, eb);
            if (we) chk($sformatf("%s:b%0d_wdata", tag, b), bus.bus_wdata, ewd);
            chk($sformatf("%s:b%0d_no_rsp", tag, b), rsp_valid, 0);
            bus.bus_gnt = 1'b1;
            @(negedge clk);
            bus.bus_gnt = 1'b0;
            if (!we) begin
                chk($sformatf("%s:b%0d_wait_no_req", tag, b), bus.bus_req, 0);
                bus.bus_rvalid = 1'b1;
                bus.bus_rdata  = w;
                @(negedge clk);
                bus.bus_rvalid = 1'b0;
                bus.bus_rdata  = 32'h0;
            end
        end
        chk({tag, ":rsp_valid"}, rsp_valid, 1);
        chk({tag, ":rdata"}, rdata, erd);
        chk({tag, ":rsp_no_req"}, bus.bus_req, 0);
        @(negedge clk);
        chk({tag, ":rsp_pulse"}, rsp_valid, 0);
        chk({tag, ":back_idle"}, req_ready, 1);
        chk({tag, ":rdata_hold"}, rdata, erd);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        mem_we         = 1'b0;
        mem_ctrl       = 3'b000;
        addr           = 32'h0;
        wdata          = 32'h0;
        bus.bus_gnt    = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata  = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst:bus_req", bus.bus_req, 0);
        chk("rst:bus_we", bus.bus_we, 0);
        chk("rst:bus_addr", bus.bus_addr, 0);
        chk("rst:bus_be", bus.bus_be, 0);
        chk("rst:bus_wdata", bus.bus_wdata, 0);
        chk("rst:rsp_valid", rsp_valid, 0);
        chk("rst:rdata", rdata, 0);
        chk("rst:req_ready", req_ready, 1);
        chk("rst:state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // aligned LW: 3 cycles, one beat
        run_op("lw_aligned", 1'b0, LOAD_W, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h0,
               32'h100, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h0, 1, 32'hDEADBEEF);
        run_op("lb_sign", 1'b0, LOAD_B, 32'h103, 32'h0, 0, 32'h80000000, 32'h0,
               32'h100, 32'h0, 4'b1000, 4'b0000, 32'h0, 32'h0, 1, 32'hFFFFFF80);
        run_op("lbu_zero", 1'b0, LOAD_BU, 32'h103, 32'h0, 0, 32'h80000000, 32'h0,
               32'h100, 32'h0, 4'b1000, 4'b0000, 32'h0, 32'h0, 1, 32'h00000080);
        // split SW: 3 cycles, two beats
        run_op("sw_split", 1'b1, STORE_W, 32'h102, 32'h11223344, 0, 32'h0, 32'h0,
               32'h100, 32'h104, 4'b1100, 4'b0011, 32'h33440000, 32'h00001122, 2, 32'h0);
        // split LHU: 5 cycles
        run_op("lhu_split", 1'b0, LOAD_HU, 32'h103, 32'h0, 0, 32'hAB000000, 32'h000000CD,
               32'h100, 32'h104, 4'b1000, 4'b0001, 32'h0, 32'h0, 2, 32'h0000CDAB);
        // SH with 3-cycle grant stall and beat1 wrapping to address 0
        run_op("sh_stall_wrap", 1'b1, STORE_H, 32'hFFFFFFFF, 32'h0000BEEF, 3, 32'h0, 32'h0,
               32'hFFFFFFFC, 32'h00000000, 4'b1000, 4'b0001, 32'hEF000000, 32'h000000BE,
               2, 32'h0);
        // aligned SB: 2 cycles
        run_op("sb_aligned", 1'b1, STORE_B, 32'h201, 32'h000000A5, 0, 32'h0, 32'h0,
               32'h200, 32'h0, 4'b0010, 4'b0000, 32'h0000A500, 32'h0, 1, 32'h0);
        // LH with stray rvalid during a 1-cycle stall
        run_op("lh_sign_stall", 1'b0, LOAD_H, 32'h102, 32'h0, 1, 32'h80010000, 32'h0,
               32'h100, 32'h0, 4'b1100, 4'b0000, 32'h0, 32'h0, 1, 32'hFFFF8001);
        // reserved load code behaves as LW
        run_op("ld_reserved", 1'b0, 3'b011, 32'h104, 32'h0, 0, 32'h12345678, 32'h0,
               32'h104, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h0, 1, 32'h12345678);
        // reserved store code behaves as SW
        run_op("st_reserved", 1'b1, 3'b111, 32'h300, 32'hCAFEBABE, 0, 32'h0, 32'h0,
               32'h300, 32'h0, 4'b1111, 4'b0000, 32'hCAFEBABE, 32'h0, 1, 32'h0);

        // reset during WAIT0
        req_valid = 1'b1;
        mem_we    = 1'b0;
        mem_ctrl  = LOAD_W;
        addr      = 32'h100;
        @(negedge clk);
        req_valid   = 1'b0;
        bus.bus_gnt = 1'b1;
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        chk("rst_mid:in_wait0", dbg_state, ST_WAIT0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid:state", dbg_state, ST_IDLE);
        chk("rst_mid:bus_req", bus.bus_req, 0);
        chk("rst_mid:rsp_valid", rsp_valid, 0);
        chk("rst_mid:req_ready", req_ready, 1);
        chk("rst_mid:rdata", rdata, 0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata  = 32'h55555555;
        @(negedge clk);
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata  = 32'h0;
        chk("rst_mid:no_rsp0", rsp_valid, 0);
        chk("rst_mid:idle0", dbg_state, ST_IDLE);
        @(negedge clk);
        chk("rst_mid:no_rsp1", rsp_valid, 0);
        chk("rst_mid:rdata_kept", rdata, 0);
        run_op("after_rst", 1'b0, LOAD_W, 32'h200, 32'h0, 0, 32'hCAFEF00D, 32'h0,
               32'h200, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h0, 1, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench time limit reached");
    end
endmodule
